// File: rtl/seven_seg_pkg.sv
// Shared types and segment patterns for the seven-segment scanner.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF  = 7'h7F;
    localparam seg_t SEG_DASH = 7'h3F;

    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: bcd (4-bit digit in), seg (pattern out, dash for 10..15).
module bcd_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver with per-frame snapshot,
// leading-zero blanking and anode dead time between slots.
// Ports: clk_i, rst_i (sync, active-high), enable_i, blank_lz_i,
//        digits_i (packed BCD), dp_i, an_o / seg_o / dp_o (active-low).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  blank_lz_i,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);

    logic [PW-1:0]         presc_q;
    logic [IW-1:0]         idx_q;
    logic [4*N_DIGITS-1:0] snap_dig_q;
    logic [N_DIGITS-1:0]   snap_dp_q;

    logic presc_last;
    logic idx_last;
    logic load;

    assign presc_last = (presc_q == PW'(REFRESH_DIV - 1));
    assign idx_last   = (idx_q == IW'(N_DIGITS - 1));
    assign load = enable_i && (presc_q == '0) && (idx_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            idx_q      <= '0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
        end else if (enable_i) begin
            if (load) begin
                snap_dig_q <= digits_i;
                snap_dp_q  <= dp_i;
            end
            if (presc_last) begin
                presc_q <= '0;
                idx_q   <= idx_last ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    logic [3:0]          cur_dig;
    logic                cur_dp;
    logic                zero_run;
    logic                blank;
    logic [N_DIGITS-1:0] an_lit;
    seg_t                cur_seg;

    // Walk from the top digit down; zero_run stays set while every
    // digit at or above k is zero, which is exactly the blank test.
    always_comb begin
        cur_dig  = '0;
        cur_dp   = 1'b0;
        zero_run = 1'b1;
        blank    = 1'b0;
        an_lit   = '1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (snap_dig_q[4*k +: 4] == 4'd0);
            if (idx_q == IW'(k)) begin
                cur_dig   = snap_dig_q[4*k +: 4];
                cur_dp    = snap_dp_q[k];
                an_lit[k] = 1'b0;
                if (k != 0) begin
                    blank = blank_lz_i && zero_run;
                end
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd (cur_dig),
        .seg (cur_seg)
    );

    logic [N_DIGITS-1:0] an_d;
    seg_t                seg_d;
    logic                dp_d;
    logic                lit;

    assign lit = enable_i && !blank &&
                 (presc_q >= PW'(DEAD_CYC));

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = an_lit;
            seg_d = cur_seg;
            dp_d  = ~cur_dp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_o  <= '1;
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= an_d;
            seg_o <= seg_d;
            dp_o  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, 8-cycle slots,
// 2-cycle dead time) using a queue of expected slot observations.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        blz;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    seven_seg_scanner #(
        .N_DIGITS    (4),
        .REFRESH_DIV (8),
        .DEAD_CYC    (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (en),
        .blank_lz_i (blz),
        .digits_i   (digits),
        .dp_i       (dp),
        .an_o       (an_o),
        .seg_o      (seg_o),
        .dp_o       (dp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         at;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         chk_seg;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        step();
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        edge_n = 0;
    endtask

    // Edge after which the output reflects frame f, slot s, prescaler p.
    function automatic int at(input int f, input int s, input int p);
        return 32 * f + 8 * s + p + 1;
    endfunction

    function automatic logic [3:0] lit(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << s);
    endfunction

    function automatic void push(input string nm, input int n,
                                 input logic [3:0] a,
                                 input logic [6:0] s,
                                 input logic d, input bit cs);
        exp_t x;
        x.name = nm;
        x.at = n;
        x.an = a;
        x.seg = s;
        x.dp = d;
        x.chk_seg = cs;
        q.push_back(x);
    endfunction

    task automatic test_reset();
        en = 1'b1; blz = 1'b0; digits = 16'h0000; dp = 4'h0;
        do_reset();
        tests++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1) begin
            fails++;
            $display("FAIL reset: an=%b seg=%h dp=%b, want 1111/7f/1",
                     an_o, seg_o, dp_o);
        end
        for (int n = 1; n <= 11; n++) begin
            if (n <= 2 || n == 9 || n == 10)
                push("timing_off", n, 4'hF, 7'h7F, 1'b1, 1'b1);
            else if (n <= 8)
                push("timing_s0", n, 4'b1110, 7'h40, 1'b1, 1'b1);
            else
                push("timing_s1", n, 4'b1101, 7'h40, 1'b1, 1'b1);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            run_to(e.at);
            tests++;
            if (an_o !== e.an || dp_o !== e.dp ||
                (e.chk_seg && seg_o !== e.seg)) begin
                fails++;
                $display("FAIL %s@%0d: an=%b seg=%h dp=%b want %b/%h/%b",
                         e.name, e.at, an_o, seg_o, dp_o,
                         e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_decode();
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        en = 1'b1; blz = 1'b0; digits = 16'h1234; dp = 4'b0100;
        do_reset();
        for (int s = 0; s < 4; s++)
            push("decode", at(0, s, 4), lit(s), exp_seg[s],
                 (s == 2) ? 1'b0 : 1'b1, 1'b1);
        while (q.size() > 0) begin
            e = q.pop_front();
            run_to(e.at);
            tests++;
            if (an_o !== e.an || dp_o !== e.dp ||
                (e.chk_seg && seg_o !== e.seg)) begin
                fails++;
                $display("FAIL %s@%0d: an=%b seg=%h dp=%b want %b/%h/%b",
                         e.name, e.at, an_o, seg_o, dp_o,
                         e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_tearing();
        en = 1'b1; blz = 1'b0; digits = 16'h0099; dp = 4'h0;
        do_reset();
        push("tear_s0", at(0, 0, 4), lit(0), 7'h10, 1'b1, 1'b1);
        push("tear_s1a", at(0, 1, 2), lit(1), 7'h10, 1'b1, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                run_to(e.at);
                tests++;
                if (an_o !== e.an || dp_o !== e.dp ||
                    (e.chk_seg && seg_o !== e.seg)) begin
                    fails++;
                    $display("FAIL %s@%0d: an=%b seg=%h dp=%b want %b/%h/%b",
                             e.name, e.at, an_o, seg_o, dp_o,
                             e.an, e.seg, e.dp);
                end
            end
            if (pass == 0) begin
                digits = 16'h0100;
                push("tear_s1b", at(0, 1, 6), lit(1), 7'h10, 1'b1, 1'b1);
                push("tear_s2", at(0, 2, 4), lit(2), 7'h40, 1'b1, 1'b1);
                push("tear_s3", at(0, 3, 4), lit(3), 7'h40, 1'b1, 1'b1);
                push("new_s0", at(1, 0, 4), lit(0), 7'h40, 1'b1, 1'b1);
                push("new_s1", at(1, 1, 4), lit(1), 7'h40, 1'b1, 1'b1);
                push("new_s2", at(1, 2, 4), lit(2), 7'h79, 1'b1, 1'b1);
                push("new_s3", at(1, 3, 4), lit(3), 7'h40, 1'b1, 1'b1);
            end
        end
    endtask

    task automatic test_blanking();
        en = 1'b1; blz = 1'b1; digits = 16'h0050; dp = 4'b1100;
        do_reset();
        push("blz_s0", at(0, 0, 4), lit(0), 7'h40, 1'b1, 1'b1);
        push("blz_s1", at(0, 1, 4), lit(1), 7'h12, 1'b1, 1'b1);
        push("blz_s2", at(0, 2, 4), 4'hF, 7'h7F, 1'b1, 1'b0);
        push("blz_s3", at(0, 3, 4), 4'hF, 7'h7F, 1'b1, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                run_to(e.at);
                tests++;
                if (an_o !== e.an || dp_o !== e.dp ||
                    (e.chk_seg && seg_o !== e.seg)) begin
                    fails++;
                    $display("FAIL %s@%0d: an=%b seg=%h dp=%b want %b/%h/%b",
                             e.name, e.at, an_o, seg_o, dp_o,
                             e.an, e.seg, e.dp);
                end
            end
            if (pass == 0) begin
                digits = 16'h0000;
                dp = 4'h0;
                push("zero_s0", at(1, 0, 4), lit(0), 7'h40, 1'b1, 1'b1);
                push("zero_s1", at(1, 1, 4), 4'hF, 7'h7F, 1'b1, 1'b0);
                push("zero_s2", at(1, 2, 4), 4'hF, 7'h7F, 1'b1, 1'b0);
                push("zero_s3", at(1, 3, 4), 4'hF, 7'h7F, 1'b1, 1'b0);
            end
        end
        blz = 1'b0;
    endtask

    task automatic test_invalid();
        en = 1'b1; blz = 1'b0; digits = 16'hA00F; dp = 4'h0;
        do_reset();
        push("inv_s0", at(0, 0, 4), lit(0), 7'h3F, 1'b1, 1'b1);
        push("inv_s1", at(0, 1, 4), lit(1), 7'h40, 1'b1, 1'b1);
        push("inv_s2", at(0, 2, 4), lit(2), 7'h40, 1'b1, 1'b1);
        push("inv_s3", at(0, 3, 4), lit(3), 7'h3F, 1'b1, 1'b1);
        while (q.size() > 0) begin
            e = q.pop_front();
            run_to(e.at);
            tests++;
            if (an_o !== e.an || dp_o !== e.dp ||
                (e.chk_seg && seg_o !== e.seg)) begin
                fails++;
                $display("FAIL %s@%0d: an=%b seg=%h dp=%b want %b/%h/%b",
                         e.name, e.at, an_o, seg_o, dp_o,
                         e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_enable_reset();
        en = 1'b1; blz = 1'b0; digits = 16'h1234; dp = 4'h0;
        do_reset();
        run_to(at(0, 2, 4));
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1) begin
                fails++;
                $display("FAIL disable_%0d: an=%b seg=%h dp=%b want 1111/7f/1",
                         i, an_o, seg_o, dp_o);
            end
        end
        en = 1'b1;
        push("resume_p5", at(0, 2, 5), lit(2), 7'h24, 1'b1, 1'b1);
        push("resume_p7", at(0, 2, 7), lit(2), 7'h24, 1'b1, 1'b1);
        push("resume_dead", at(0, 3, 0), 4'hF, 7'h7F, 1'b1, 1'b1);
        push("resume_s3", at(0, 3, 2), lit(3), 7'h79, 1'b1, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                run_to(e.at);
                tests++;
                if (an_o !== e.an || dp_o !== e.dp ||
                    (e.chk_seg && seg_o !== e.seg)) begin
                    fails++;
                    $display("FAIL %s@%0d: an=%b seg=%h dp=%b want %b/%h/%b",
                             e.name, e.at, an_o, seg_o, dp_o,
                             e.an, e.seg, e.dp);
                end
            end
            if (pass == 0) begin
                run_to(at(0, 3, 4));
                digits = 16'h5678;
                rst = 1'b1;
                step();
                tests++;
                if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1) begin
                    fails++;
                    $display("FAIL midrst: an=%b seg=%h dp=%b want 1111/7f/1",
                             an_o, seg_o, dp_o);
                end
                rst = 1'b0;
                edge_n = 0;
                push("rst_off1", 1, 4'hF, 7'h7F, 1'b1, 1'b1);
                push("rst_off2", 2, 4'hF, 7'h7F, 1'b1, 1'b1);
                push("rst_s0", 3, lit(0), 7'h00, 1'b1, 1'b1);
                push("rst_s1", at(0, 1, 4), lit(1), 7'h78, 1'b1, 1'b1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; blz = 1'b0;
        digits = 16'h0000; dp = 4'h0;
        test_reset();
        test_decode();
        test_tearing();
        test_blanking();
        test_invalid();
        test_enable_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
